// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and shared constants for the alu block.
`default_nettype none

package alu_pkg;

  localparam int   ALU_WIDTH   = 8;
  localparam logic ALU_RST_BIT = 1'b0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// alu_core: combinational result and (with ALU_FLAGS_EN) carry/zero computation.
`default_nettype none

module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             zero
`endif
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] sh;
  assign sh = b[SHW-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_SHL: result = a << sh;
      ALU_SHR: result = a >> sh;
      default: result = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Last bit shifted out: a[WIDTH-sh] for left, a[sh-1] for right (WIDTH is a power of two).
  logic [SHW-1:0] shl_idx;
  logic [SHW-1:0] shr_idx;

  always_comb begin
    shl_idx = -sh;
    shr_idx = sh - SHW'(1);
    carry   = 1'b0;
    case (op)
      ALU_ADD: carry = (result < a);
      ALU_SUB: carry = (a < b);
      ALU_SHL: carry = (sh != '0) && a[shl_idx];
      ALU_SHR: carry = (sh != '0) && a[shr_idx];
      default: carry = 1'b0;
    endcase
    zero = (result == '0);
  end
`endif

endmodule

`default_nettype wire

// File: rtl/alu.sv
// alu: registered 8-op ALU; optional carry/zero flags with macro ALU_FLAGS_EN.
`default_nettype none

module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] alu_o
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry_o,
  output logic             zero_o
`endif
);

  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] alu_d, alu_q;

`ifdef ALU_FLAGS_EN
  logic core_carry, core_zero;
  logic carry_d, carry_q;
  logic zero_d, zero_q;
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .op     (alu_op_e'(op)),
    .result (core_result)
`ifdef ALU_FLAGS_EN
    ,
    .carry  (core_carry),
    .zero   (core_zero)
`endif
  );

  always_comb begin
    alu_d = core_result;
`ifdef ALU_FLAGS_EN
    carry_d = core_carry;
    zero_d  = core_zero;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q   <= {WIDTH{ALU_RST_BIT}};
`ifdef ALU_FLAGS_EN
      carry_q <= ALU_RST_BIT;
      zero_q  <= ALU_RST_BIT;
`endif
    end else begin
      alu_q   <= alu_d;
`ifdef ALU_FLAGS_EN
      carry_q <= carry_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign alu_o = alu_q;
`ifdef ALU_FLAGS_EN
  assign carry_o = carry_q;
  assign zero_o  = zero_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of alu against an arithmetic reference model.
`default_nettype none

module tb_alu;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [2:0] op = 3'd0;
  logic [7:0] alu_o;
`ifdef ALU_FLAGS_EN
  logic       carry_o;
  logic       zero_o;
`endif

  int tests = 0;
  int fails = 0;

  alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .op    (op),
    .alu_o (alu_o)
`ifdef ALU_FLAGS_EN
    ,
    .carry_o (carry_o),
    .zero_o  (zero_o)
`endif
  );

  always #5 if (clk_en) clk = ~clk;

  // Reference model in plain integer arithmetic.
  function automatic int model_res(input int ia, input int ib, input int iop);
    int n;
    n = ib % 8;
    case (iop)
      0: return (ia + ib) % 256;
      1: return (ia - ib + 256) % 256;
      2: return ia & ib;
      3: return ia | ib;
      4: return ia ^ ib;
      5: return 255 - ia;
      6: return (ia * (2 ** n)) % 256;
      default: return ia / (2 ** n);
    endcase
  endfunction

  function automatic int model_carry(input int ia, input int ib, input int iop);
    int n;
    n = ib % 8;
    case (iop)
      0: return (ia + ib > 255) ? 1 : 0;
      1: return (ia < ib) ? 1 : 0;
      6: return (n == 0) ? 0 : ((ia * (2 ** n)) / 256) % 2;
      7: return (n == 0) ? 0 : (ia / (2 ** (n - 1))) % 2;
      default: return 0;
    endcase
  endfunction

  // Issue one operation, let one edge capture it, sample 1 time unit later.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop);
    @(negedge clk);
    a  = ia;
    b  = ib;
    op = iop;
    @(posedge clk);
    #1;
  endtask

  task automatic check_op(input string name, input logic [7:0] ia, input logic [7:0] ib,
                          input logic [2:0] iop);
    logic [7:0] exp_r;
    exp_r = 8'(model_res(int'(ia), int'(ib), int'(iop)));
    issue(ia, ib, iop);
    tests++;
    if (alu_o !== exp_r) begin
      fails++;
      $display("FAIL %s: a=%h b=%h op=%0d alu_o=%h expected %h", name, ia, ib, iop, alu_o, exp_r);
    end
`ifdef ALU_FLAGS_EN
    tests++;
    if (carry_o !== 1'(model_carry(int'(ia), int'(ib), int'(iop)))) begin
      fails++;
      $display("FAIL %s carry: a=%h b=%h op=%0d carry_o=%b expected %0d", name, ia, ib, iop,
               carry_o, model_carry(int'(ia), int'(ib), int'(iop)));
    end
    tests++;
    if (zero_o !== (exp_r == 8'h00)) begin
      fails++;
      $display("FAIL %s zero: zero_o=%b expected %b", name, zero_o, exp_r == 8'h00);
    end
`endif
  endtask

  task automatic test_reset();
    a  = 8'h55;
    b  = 8'h00;
    op = 3'd0;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (alu_o !== 8'h00) begin
      fails++;
      $display("FAIL reset: alu_o=%h expected 00", alu_o);
    end
`ifdef ALU_FLAGS_EN
    tests++;
    if (carry_o !== 1'b0 || zero_o !== 1'b0) begin
      fails++;
      $display("FAIL reset flags: carry_o=%b zero_o=%b expected 0 0", carry_o, zero_o);
    end
`endif
    #2 rst = 1'b0;
    clk_en = 1'b1;
  endtask

  task automatic test_directed();
    check_op("add_wrap",   8'hFF, 8'h01, 3'd0);
    check_op("sub_borrow", 8'h10, 8'h20, 3'd1);
    check_op("and",        8'hCA, 8'h5F, 3'd2);
    check_op("or",         8'hCA, 8'h5F, 3'd3);
    check_op("xor",        8'hCA, 8'h5F, 3'd4);
    check_op("not",        8'hCA, 8'h5F, 3'd5);
    check_op("shl3",       8'h81, 8'h03, 3'd6);
    check_op("shr3",       8'h81, 8'h03, 3'd7);
    check_op("shr1",       8'h81, 8'h01, 3'd7);
    check_op("shl0",       8'hA5, 8'hF8, 3'd6);
    check_op("shr0",       8'hA5, 8'h08, 3'd7);
    check_op("sub_wrap",   8'h00, 8'h01, 3'd1);
  endtask

  // Spot-check literal values from the opcode table independently of the model.
  task automatic test_literals();
    issue(8'hCA, 8'h5F, 3'd4);
    tests++;
    if (alu_o !== 8'h95) begin
      fails++;
      $display("FAIL literal_xor: alu_o=%h expected 95", alu_o);
    end
    issue(8'h81, 8'h03, 3'd6);
    tests++;
    if (alu_o !== 8'h08) begin
      fails++;
      $display("FAIL literal_shl: alu_o=%h expected 08", alu_o);
    end
  endtask

  task automatic test_hold();
    logic [7:0] exp_r;
    issue(8'h33, 8'h44, 3'd0);
    exp_r = 8'h77;
    a  = 8'hFF;
    b  = 8'hFF;
    op = 3'd5;
    #3;
    tests++;
    if (alu_o !== exp_r) begin
      fails++;
      $display("FAIL hold: alu_o=%h expected %h", alu_o, exp_r);
    end
  endtask

  task automatic test_mid_reset();
    issue(8'h12, 8'h34, 3'd0);
    @(negedge clk);
    a  = 8'h0F;
    b  = 8'h01;
    op = 3'd0;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (alu_o !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset: alu_o=%h expected 00", alu_o);
    end
    @(posedge clk);
    #1;
    tests++;
    if (alu_o !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset_hold: alu_o=%h expected 00", alu_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (alu_o !== 8'h10) begin
      fails++;
      $display("FAIL post_reset: alu_o=%h expected 10", alu_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int pass = 0; pass < 3; pass++) begin
      for (int k = 0; k < 7; k++) begin
        check_op("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'(k));
      end
    end
    check_op("random_shr", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'd7);
    for (int k = 0; k < 40; k++) begin
      check_op("random_mix", 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_literals();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
